// File: rtl/idli_issue_m_if.sv
// Decoder/EX handshake bundle for the idli issue stage.
// master: issue stage side. slave: decoder plus EX side.
interface idli_issue_m_if #(
    parameter int OP_W = 8
);
    logic [OP_W-1:0] i_iss_op;
    logic            i_iss_op_words;
    logic            i_iss_op_vld;
    logic            o_iss_op_rdy;
    logic [OP_W-1:0] o_iss_op;
    logic            o_iss_op_vld;
    logic            i_iss_op_acp;
    logic [3:0]      o_iss_pc;
    logic [3:0]      o_iss_pc_next;

    modport master (
        input  i_iss_op, i_iss_op_words, i_iss_op_vld, i_iss_op_acp,
        output o_iss_op_rdy, o_iss_op, o_iss_op_vld, o_iss_pc, o_iss_pc_next
    );

    modport slave (
        output i_iss_op, i_iss_op_words, i_iss_op_vld, i_iss_op_acp,
        input  o_iss_op_rdy, o_iss_op, o_iss_op_vld, o_iss_pc, o_iss_pc_next
    );
endinterface

// File: rtl/idli_issue_m.sv
// idli issue stage: op FIFO with per-op PC tracking and nibble-serial PC output to EX.
// Optional IDLI_ISS_PERF_EN adds saturating issued/stall performance counters.
module idli_issue_m #(
    parameter int          DEPTH  = 2,
    parameter logic [15:0] PC_RST = 16'h0000,
    parameter int          OP_W   = 8
) (
    input  logic           i_iss_gck,
    input  logic           i_iss_rst,
    idli_issue_m_if.master iss,
    input  logic           i_iss_redir,
    input  logic [15:0]    i_iss_redir_pc
`ifdef IDLI_ISS_PERF_EN
    ,
    output logic [15:0]    o_iss_perf_issued,
    output logic [15:0]    o_iss_perf_stall
`endif
);
    typedef logic [OP_W-1:0] op_t;

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    op_t              mem_op_r  [DEPTH];
    logic [15:0]      mem_pc_r  [DEPTH];
    logic [15:0]      mem_pcn_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic [15:0]      fetch_pc_r;
    logic [15:0]      pc_sh_r;
    logic [15:0]      pcn_sh_r;
    logic [1:0]       ser_cnt_r;
    logic             ser_busy_r;

    logic             full_s;
    logic             empty_s;
    logic             rdy_s;
    logic             vld_s;
    logic             push_s;
    logic             pop_s;
    logic [15:0]      pc_inc_s;

    assign full_s   = (count_r == CNT_W'(DEPTH));
    assign empty_s  = (count_r == {CNT_W{1'b0}});
    assign rdy_s    = !full_s;
    assign vld_s    = !empty_s;
    assign push_s   = iss.i_iss_op_vld && rdy_s && !i_iss_redir;
    assign pop_s    = vld_s && iss.i_iss_op_acp;
    assign pc_inc_s = fetch_pc_r + (iss.i_iss_op_words ? 16'd2 : 16'd1);

    assign iss.o_iss_op_rdy  = rdy_s;
    assign iss.o_iss_op_vld  = vld_s;
    assign iss.o_iss_op      = mem_op_r[rd_ptr_r];
    assign iss.o_iss_pc      = pc_sh_r[3:0];
    assign iss.o_iss_pc_next = pcn_sh_r[3:0];

    // Entry storage: op plus its fetch PC and sequential next PC.
    always_ff @(posedge i_iss_gck) begin
        if (i_iss_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_op_r[i]  <= {OP_W{1'b0}};
                mem_pc_r[i]  <= 16'h0000;
                mem_pcn_r[i] <= 16'h0000;
            end
        end else if (push_s) begin
            mem_op_r[wr_ptr_r]  <= iss.i_iss_op;
            mem_pc_r[wr_ptr_r]  <= fetch_pc_r;
            mem_pcn_r[wr_ptr_r] <= pc_inc_s;
        end else begin
            mem_op_r[wr_ptr_r] <= mem_op_r[wr_ptr_r];
        end
    end

    // Pointers and occupancy; a redirect empties the buffer outright.
    always_ff @(posedge i_iss_gck) begin
        if (i_iss_rst || i_iss_redir) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            else        wr_ptr_r <= wr_ptr_r;
            if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            else        rd_ptr_r <= rd_ptr_r;
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Fetch PC follows pushes and jumps on redirect.
    always_ff @(posedge i_iss_gck) begin
        if (i_iss_rst)        fetch_pc_r <= PC_RST;
        else if (i_iss_redir) fetch_pc_r <= i_iss_redir_pc;
        else if (push_s)      fetch_pc_r <= pc_inc_s;
        else                  fetch_pc_r <= fetch_pc_r;
    end

    // Serial PC shifters: reload on transfer, then four zero-filling nibble shifts.
    always_ff @(posedge i_iss_gck) begin
        if (i_iss_rst) begin
            pc_sh_r    <= 16'h0000;
            pcn_sh_r   <= 16'h0000;
            ser_cnt_r  <= 2'd0;
            ser_busy_r <= 1'b0;
        end else if (pop_s) begin
            pc_sh_r    <= mem_pc_r[rd_ptr_r];
            pcn_sh_r   <= mem_pcn_r[rd_ptr_r];
            ser_cnt_r  <= 2'd0;
            ser_busy_r <= 1'b1;
        end else if (ser_busy_r) begin
            pc_sh_r    <= {4'h0, pc_sh_r[15:4]};
            pcn_sh_r   <= {4'h0, pcn_sh_r[15:4]};
            ser_cnt_r  <= ser_cnt_r + 2'd1;
            ser_busy_r <= (ser_cnt_r != 2'd3);
        end else begin
            pc_sh_r    <= pc_sh_r;
            pcn_sh_r   <= pcn_sh_r;
            ser_cnt_r  <= ser_cnt_r;
            ser_busy_r <= 1'b0;
        end
    end

`ifdef IDLI_ISS_PERF_EN
    logic [15:0] perf_issued_r;
    logic [15:0] perf_stall_r;

    // Saturating transfer and stall counters.
    always_ff @(posedge i_iss_gck) begin
        if (i_iss_rst) begin
            perf_issued_r <= 16'h0000;
            perf_stall_r  <= 16'h0000;
        end else begin
            if (pop_s && (perf_issued_r != 16'hFFFF)) perf_issued_r <= perf_issued_r + 16'd1;
            else                                      perf_issued_r <= perf_issued_r;
            if (vld_s && !iss.i_iss_op_acp && (perf_stall_r != 16'hFFFF))
                perf_stall_r <= perf_stall_r + 16'd1;
            else
                perf_stall_r <= perf_stall_r;
        end
    end

    assign o_iss_perf_issued = perf_issued_r;
    assign o_iss_perf_stall  = perf_stall_r;
`endif
endmodule

// File: tb/tb_idli_issue_m.sv
// Directed self-checking bench for idli_issue_m (DEPTH=2, PC_RST=16'h1230).
module tb_idli_issue_m;
    logic        clk;
    logic        rst;
    logic        redir;
    logic [15:0] redir_pc;
    logic [15:0] pc_v;
    logic [15:0] pcn_v;
    int          checks_n;
    int          errors_n;
`ifdef IDLI_ISS_PERF_EN
    logic [15:0] perf_issued;
    logic [15:0] perf_stall;
`endif

    idli_issue_m_if #(.OP_W(8)) bus ();

    idli_issue_m #(
        .DEPTH  (2),
        .PC_RST (16'h1230),
        .OP_W   (8)
    ) dut (
        .i_iss_gck      (clk),
        .i_iss_rst      (rst),
        .iss            (bus),
        .i_iss_redir    (redir),
        .i_iss_redir_pc (redir_pc)
`ifdef IDLI_ISS_PERF_EN
        ,
        .o_iss_perf_issued (perf_issued),
        .o_iss_perf_stall  (perf_stall)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_n++;
        if (obs !== exp) begin
            errors_n++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Collect four serial nibbles starting at counter 0, advancing one cycle per nibble.
    task automatic ser_read(output logic [15:0] pc, output logic [15:0] pcn);
        for (int i = 0; i < 4; i++) begin
            pc[4*i +: 4]  = bus.o_iss_pc;
            pcn[4*i +: 4] = bus.o_iss_pc_next;
            cyc();
        end
    endtask

    initial begin
        checks_n = 0;
        errors_n = 0;
        rst = 1'b1;
        redir = 1'b0;
        redir_pc = 16'h0000;
        bus.i_iss_op = 8'h00;
        bus.i_iss_op_words = 1'b0;
        bus.i_iss_op_vld = 1'b0;
        bus.i_iss_op_acp = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
        check_eq("rst_vld", {31'd0, bus.o_iss_op_vld}, 32'd0);
        check_eq("rst_rdy", {31'd0, bus.o_iss_op_rdy}, 32'd1);
        check_eq("rst_pc", {28'd0, bus.o_iss_pc}, 32'd0);
        check_eq("rst_pcn", {28'd0, bus.o_iss_pc_next}, 32'd0);

        // 1-word op from reset PC, acp held high
        bus.i_iss_op = 8'hA1; bus.i_iss_op_vld = 1'b1; bus.i_iss_op_acp = 1'b1;
        cyc();
        bus.i_iss_op_vld = 1'b0;
        check_eq("t1_vld", {31'd0, bus.o_iss_op_vld}, 32'd1);
        check_eq("t1_op", {24'd0, bus.o_iss_op}, 32'hA1);
        cyc();
        check_eq("t1_vld_after", {31'd0, bus.o_iss_op_vld}, 32'd0);
        ser_read(pc_v, pcn_v);
        check_eq("t1_pc", {16'd0, pc_v}, 32'h1230);
        check_eq("t1_pcn", {16'd0, pcn_v}, 32'h1231);
        check_eq("t1_pc_idle", {28'd0, bus.o_iss_pc}, 32'd0);

        // 2-word op at FFFF wraps next PC
        bus.i_iss_op_acp = 1'b0;
        redir = 1'b1; redir_pc = 16'hFFFF;
        cyc();
        redir = 1'b0;
        check_eq("t2_redir_vld", {31'd0, bus.o_iss_op_vld}, 32'd0);
        bus.i_iss_op = 8'hB2; bus.i_iss_op_words = 1'b1; bus.i_iss_op_vld = 1'b1;
        cyc();
        check_eq("t2_op_b2", {24'd0, bus.o_iss_op}, 32'hB2);
        bus.i_iss_op = 8'hC3; bus.i_iss_op_words = 1'b0; bus.i_iss_op_acp = 1'b1;
        cyc();
        bus.i_iss_op_vld = 1'b0; bus.i_iss_op_acp = 1'b0;
        ser_read(pc_v, pcn_v);
        check_eq("t2_pc_b2", {16'd0, pc_v}, 32'hFFFF);
        check_eq("t2_pcn_b2", {16'd0, pcn_v}, 32'h0001);
        check_eq("t2_op_c3_held", {24'd0, bus.o_iss_op}, 32'hC3);
        check_eq("t2_vld_c3", {31'd0, bus.o_iss_op_vld}, 32'd1);
        bus.i_iss_op_acp = 1'b1;
        cyc();
        bus.i_iss_op_acp = 1'b0;
        ser_read(pc_v, pcn_v);
        check_eq("t2_pc_c3", {16'd0, pc_v}, 32'h0001);
        check_eq("t2_pcn_c3", {16'd0, pcn_v}, 32'h0002);

        // Fill with acp low: rdy drops after 2nd push, 3rd op refused
        bus.i_iss_op = 8'hD1; bus.i_iss_op_vld = 1'b1;
        cyc();
        check_eq("t3_rdy_1", {31'd0, bus.o_iss_op_rdy}, 32'd1);
        bus.i_iss_op = 8'hD2;
        cyc();
        check_eq("t3_rdy_full", {31'd0, bus.o_iss_op_rdy}, 32'd0);
        bus.i_iss_op = 8'hD3;
        cyc();
        check_eq("t3_rdy_still", {31'd0, bus.o_iss_op_rdy}, 32'd0);
        check_eq("t3_op_stable", {24'd0, bus.o_iss_op}, 32'hD1);
        bus.i_iss_op_vld = 1'b0; bus.i_iss_op_acp = 1'b1;
        cyc();
        bus.i_iss_op_acp = 1'b0;
        check_eq("t3_rdy_rise", {31'd0, bus.o_iss_op_rdy}, 32'd1);
        check_eq("t3_op_d2", {24'd0, bus.o_iss_op}, 32'hD2);
        ser_read(pc_v, pcn_v);
        check_eq("t3_pc_d1", {16'd0, pc_v}, 32'h0002);
        bus.i_iss_op_acp = 1'b1;
        cyc();
        bus.i_iss_op_acp = 1'b0;
        check_eq("t3_empty", {31'd0, bus.o_iss_op_vld}, 32'd0);
        ser_read(pc_v, pcn_v);
        check_eq("t3_pc_d2", {16'd0, pc_v}, 32'h0003);
        check_eq("t3_pcn_d2", {16'd0, pcn_v}, 32'h0004);

        // Streaming with acp every 4th cycle: back-to-back serialisation
        redir = 1'b1; redir_pc = 16'h0000;
        cyc();
        redir = 1'b0;
        bus.i_iss_op = 8'hE0; bus.i_iss_op_vld = 1'b1;
        cyc();
        bus.i_iss_op_acp = 1'b1;
        cyc();
        for (int j = 0; j < 5; j++) begin
            bus.i_iss_op_acp = 1'b0;
            for (int i = 0; i < 4; i++) begin
                pc_v[4*i +: 4]  = bus.o_iss_pc;
                pcn_v[4*i +: 4] = bus.o_iss_pc_next;
                if (i == 3) bus.i_iss_op_acp = 1'b1;
                cyc();
            end
            check_eq("t4_pc", {16'd0, pc_v}, 32'(j));
            check_eq("t4_pcn", {16'd0, pcn_v}, 32'(j + 1));
        end
        bus.i_iss_op_acp = 1'b0; bus.i_iss_op_vld = 1'b0;

        // Redirect with 2 ops buffered and a push offered in the same cycle
        redir = 1'b1; redir_pc = 16'h0100;
        cyc();
        redir = 1'b0;
        bus.i_iss_op = 8'h55; bus.i_iss_op_vld = 1'b1;
        cyc();
        bus.i_iss_op = 8'h66;
        cyc();
        check_eq("t5_full", {31'd0, bus.o_iss_op_rdy}, 32'd0);
        bus.i_iss_op = 8'h77; redir = 1'b1; redir_pc = 16'h4000;
        cyc();
        redir = 1'b0; bus.i_iss_op_vld = 1'b0;
        check_eq("t5_vld_flush", {31'd0, bus.o_iss_op_vld}, 32'd0);
        check_eq("t5_rdy_flush", {31'd0, bus.o_iss_op_rdy}, 32'd1);
        bus.i_iss_op = 8'h88; bus.i_iss_op_vld = 1'b1;
        cyc();
        bus.i_iss_op_vld = 1'b0;
        check_eq("t5_op_88", {24'd0, bus.o_iss_op}, 32'h88);
        bus.i_iss_op_acp = 1'b1;
        cyc();
        bus.i_iss_op_acp = 1'b0;
        ser_read(pc_v, pcn_v);
        check_eq("t5_pc", {16'd0, pc_v}, 32'h4000);
        check_eq("t5_pcn", {16'd0, pcn_v}, 32'h4001);

        // Reset mid-serialisation at counter=2
        redir = 1'b1; redir_pc = 16'h4321;
        cyc();
        redir = 1'b0;
        bus.i_iss_op = 8'h99; bus.i_iss_op_vld = 1'b1;
        cyc();
        bus.i_iss_op = 8'h9A; bus.i_iss_op_acp = 1'b1;
        cyc();
        bus.i_iss_op_vld = 1'b0; bus.i_iss_op_acp = 1'b0;
        cyc();
        cyc();
        check_eq("t6_pc_cnt2", {28'd0, bus.o_iss_pc}, 32'h3);
        check_eq("t6_pcn_cnt2", {28'd0, bus.o_iss_pc_next}, 32'h3);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check_eq("t6_pc_rst", {28'd0, bus.o_iss_pc}, 32'd0);
        check_eq("t6_pcn_rst", {28'd0, bus.o_iss_pc_next}, 32'd0);
        check_eq("t6_vld_rst", {31'd0, bus.o_iss_op_vld}, 32'd0);
        check_eq("t6_rdy_rst", {31'd0, bus.o_iss_op_rdy}, 32'd1);
        bus.i_iss_op = 8'hAB; bus.i_iss_op_vld = 1'b1;
        cyc();
        bus.i_iss_op_vld = 1'b0; bus.i_iss_op_acp = 1'b1;
        cyc();
        bus.i_iss_op_acp = 1'b0;
        ser_read(pc_v, pcn_v);
        check_eq("t6_fetch_pc", {16'd0, pc_v}, 32'h1230);
        check_eq("t6_fetch_pcn", {16'd0, pcn_v}, 32'h1231);

`ifdef IDLI_ISS_PERF_EN
        // 5 stall cycles then 3 transfers
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check_eq("p_rst_issued", {16'd0, perf_issued}, 32'd0);
        bus.i_iss_op_vld = 1'b1;
        cyc();
        cyc();
        bus.i_iss_op_vld = 1'b0;
        cyc();
        cyc();
        cyc();
        cyc();
        check_eq("p_stall_5", {16'd0, perf_stall}, 32'd5);
        bus.i_iss_op_acp = 1'b1;
        cyc();
        bus.i_iss_op_vld = 1'b1;
        cyc();
        bus.i_iss_op_vld = 1'b0;
        cyc();
        bus.i_iss_op_acp = 1'b0;
        cyc();
        check_eq("p_issued_3", {16'd0, perf_issued}, 32'd3);
        check_eq("p_stall_final", {16'd0, perf_stall}, 32'd5);
`endif

        $display("CHECKS %0d ERRORS %0d", checks_n, errors_n);
        $finish;
    end
endmodule

// File: doc/idli_issue_m.md
Name: idli_issue_m

Overview:
- Issue stage between the instruction decoder and the execution unit; it is the sending side of the EX op valid/accept handshake.
- Buffers decoded ops in a small FIFO and tracks the fetch PC (current and next PC) for each op.
- After each op transfers to EX, shifts that op's PC and next PC out nibble-serially, LSN first, in step with EX's 4-cycle execution.
- Redirect input flushes the buffer and reloads the PC.

Parameters:
- DEPTH, 2, number of op buffer entries; power of two, >= 2.
- PC_RST, 16'h0000, fetch PC loaded on reset.

Ports:
- i_iss_gck  input  1  clock.
- i_iss_rst  input  1  synchronous active-high reset.
- i_iss_op  input  $bits(op_t)  decoded op from decoder.
- i_iss_op_words  input  1  0: op occupies 1 word; 1: op plus immediate word (2 words).
- i_iss_op_vld  input  1  decoder presents an op.
- o_iss_op_rdy  output  1  buffer can accept an op.
- o_iss_op  output  $bits(op_t)  head op to EX.
- o_iss_op_vld  output  1  head op valid.
- i_iss_op_acp  input  1  EX accepts op.
- o_iss_pc  output  4  PC nibble of the op executing in EX.
- o_iss_pc_next  output  4  next-PC nibble of the op executing in EX.
- i_iss_redir  input  1  redirect pulse.
- i_iss_redir_pc  input  16  redirect target.

Behaviour:
- Reset is synchronous: on a clock edge with i_iss_rst=1, the FIFO empties, the fetch PC loads PC_RST, the serial shifters clear and the serial counter clears.
- Reset values: o_iss_op_vld=0, o_iss_op_rdy=1, o_iss_pc=0, o_iss_pc_next=0.
- Reset overrides every other event, including mid-serialisation.
- Push:
  - Occurs when i_iss_op_vld && o_iss_op_rdy && !i_iss_redir.
  - The entry stores the op, pc = fetch_pc, and pc_next = fetch_pc + (i_iss_op_words ? 2 : 1), computed mod 2^16 (16'hFFFF+1 wraps to 16'h0000).
  - fetch_pc is then set to pc_next.
- o_iss_op_rdy = !full. It is registered-state only, with no combinational path from i_iss_op_acp.
- Pop/transfer:
  - Occurs on an edge where o_iss_op_vld && i_iss_op_acp.
  - o_iss_op_vld = !empty.
  - o_iss_op always drives the head entry, even when invalid.
  - The head op is held stable while valid and not accepted.
- Simultaneous push and pop:
  - Allowed at any non-full count; count is unchanged.
  - When full, push is blocked by rdy=0; a pop in that cycle still occurs.
  - Read and write pointers wrap modulo DEPTH.
- Serial PC output:
  - A transfer loads the 16-bit pc and pc_next shifters and resets the 2-bit serial counter to 0.
  - On the 4 cycles after the transfer (counter 0..3), o_iss_pc and o_iss_pc_next present bits [3:0], [7:4], [11:8] and [15:12].
  - Shifters shift right by 4 each cycle, filling with zero. After 4 cycles the outputs read 0 until the next transfer.
  - A transfer on the edge ending counter=3 reloads back-to-back with no gap.
- Redirect:
  - On an edge with i_iss_redir=1, the FIFO is flushed, fetch_pc is set to i_iss_redir_pc, and any push in that cycle is dropped.
  - A pop in the same cycle still completes, and its PC serialisation proceeds.
  - Serialisation already in progress is not disturbed.
  - o_iss_op_vld=0 in the cycle after a redirect.
- Latency:
  - An op pushed into an empty FIFO is valid to EX the next cycle.
  - There is no combinational decoder-to-EX path.

Optional Feature:
- Macro: IDLI_ISS_PERF_EN.
- Enabled: adds outputs o_iss_perf_issued (16b) and o_iss_perf_stall (16b).
  - o_iss_perf_issued counts transfers.
  - o_iss_perf_stall counts cycles with o_iss_op_vld && !i_iss_op_acp.
  - Both saturate at 16'hFFFF and clear on reset.
- Disabled: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Reset with PC_RST=16'h1230; push 1-word op; acp held 1 -> op valid 1 cycle after push; o_iss_pc nibbles 0,3,2,1; o_iss_pc_next nibbles 1,3,2,1.
- Push 2-word op at fetch_pc=16'hFFFF -> pc_next=16'h0001; following op's pc = 16'h0001.
- Hold acp=0, push 3 ops, DEPTH=2 -> rdy falls after the 2nd push; 3rd op is not taken; o_iss_op stable; the first acp pops entry 0 and rdy rises the next cycle.
- Continuous push/pop with acp asserted only on every 4th cycle -> back-to-back serialisation with no gap; PCs increment 0,1,2,...
- Redirect to 16'h4000 with 2 ops buffered and a push the same cycle -> FIFO empty, push dropped, next pushed op has pc=16'h4000.
- Assert i_iss_rst during counter=2 -> next cycle: serial outputs 0, vld=0, rdy=1, fetch_pc=PC_RST. With IDLI_ISS_PERF_EN: 5 stall cycles then 3 transfers -> stall=5, issued=3.
